// File: rtl/synth_pkg.sv
// synth_pkg: shared sample type and I2S constants for the synth audio path.
package synth_pkg;
  localparam int SAMPLE_W = 24;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
  localparam int SLOT_BITS_DEF = 32;
  localparam logic LRCK_LEFT = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO with registered occupancy.
module sample_fifo #(
  parameter int W = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: buffers mixer samples and serialises them as mono Philips I2S with master BCLK/LRCK.
module i2s_dac_tx import synth_pkg::*; #(
  parameter int BCLK_HALF = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int SLOT_BITS = SLOT_BITS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SAMPLE_W-1:0]           i_sample,
  input  logic                          i_valid,
  input  logic                          i_clr_flags,
  output logic                          o_bclk,
  output logic                          o_lrck,
  output logic                          o_dacdat,
  output logic                          o_frame,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overflow,
  output logic                          o_underrun
);
  localparam int DW = $clog2(BCLK_HALF);
  localparam int SW = $clog2(2*SLOT_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF-1);
  localparam logic [SW-1:0] SLOT_R = SW'(SLOT_BITS);
  localparam logic [SW-1:0] SLOT_LAST = SW'(2*SLOT_BITS-1);
  logic [DW-1:0] div;
  logic [SW-1:0] s, c;
  logic fall, right, frame_start, pop, push, full, empty;
  logic [SAMPLE_W-1:0] head;
  sample_t hold, sh;
  assign fall = o_bclk && div == DIV_LAST;
  assign right = s >= SLOT_R;
  assign c = right ? s - SLOT_R : s;
  assign frame_start = fall && s == '0;
  assign pop = frame_start && !empty;
  // a pop in the same cycle frees the slot a full-FIFO write needs
  assign push = i_valid && (!full || pop);
  sample_fifo #(.W(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(i_sample), .pop(pop),
    .dout(head), .full(full), .empty(empty), .level(o_level)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      s <= '0;
      sh <= '0;
      hold <= '0;
      o_bclk <= 1'b0;
      o_lrck <= 1'b0;
      o_dacdat <= 1'b0;
      o_frame <= 1'b0;
      o_overflow <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      div <= div == DIV_LAST ? '0 : div + 1'b1;
      if (div == DIV_LAST) o_bclk <= ~o_bclk;
      o_frame <= frame_start;
      o_overflow <= (i_valid && full && !pop) || (o_overflow && !i_clr_flags);
      o_underrun <= (frame_start && empty) || (o_underrun && !i_clr_flags);
      if (fall) begin
        s <= s == SLOT_LAST ? '0 : s + 1'b1;
        o_lrck <= right ? LRCK_RIGHT : LRCK_LEFT;
        // c=0 is the I2S delay bit; the shifter drains to zero after bit 0
        o_dacdat <= c != '0 && sh[SAMPLE_W-1];
        if (c == '0) sh <= right ? hold : (empty ? '0 : head);
        else sh <= sh << 1;
        if (frame_start) hold <= empty ? '0 : head;
      end
    end
  end
endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: randomized scenarios checked against a cycle-count based I2S reference model.
module tb_i2s_dac_tx;
  localparam int BH = 2;
  localparam int DEPTH = 8;
  localparam int SB = 32;
  logic clk = 0, rst = 1, i_valid = 0, i_clr_flags = 0;
  logic [23:0] i_sample = '0;
  logic o_bclk, o_lrck, o_dacdat, o_frame, o_overflow, o_underrun;
  logic [3:0] o_level;
  int nvec = 0, nerr = 0;
  i2s_dac_tx #(.BCLK_HALF(BH), .FIFO_DEPTH(DEPTH), .SLOT_BITS(SB)) dut (
    .clk(clk), .rst(rst), .i_sample(i_sample), .i_valid(i_valid), .i_clr_flags(i_clr_flags),
    .o_bclk(o_bclk), .o_lrck(o_lrck), .o_dacdat(o_dacdat), .o_frame(o_frame),
    .o_level(o_level), .o_overflow(o_overflow), .o_underrun(o_underrun)
  );
  always #5 clk = ~clk;
  // Model: t counts clks since reset release; a BCLK fall every 2*BH clks, slot k-1 on the k-th fall.
  int t, slot, c;
  bit started;
  logic [23:0] q[$];
  logic [23:0] cur;
  bit e_bclk, e_lrck, e_dat, e_frame, e_ovf, e_unr;
  logic [3:0] e_level;
  always @(posedge clk) begin
    if (rst) begin
      t = 0; slot = 0; started = 0; cur = '0; q.delete();
      e_frame = 0; e_ovf = 0; e_unr = 0;
    end else begin
      t++;
      e_frame = 0;
      if (i_clr_flags) begin e_ovf = 0; e_unr = 0; end
      if (t % (2*BH) == 0) begin
        started = 1;
        slot = (t/(2*BH) - 1) % (2*SB);
        if (slot == 0) begin
          e_frame = 1;
          if (q.size() > 0) cur = q.pop_front();
          else begin cur = '0; e_unr = 1; end
        end
      end
      if (i_valid) begin
        if (q.size() < DEPTH) q.push_back(i_sample);
        else e_ovf = 1;
      end
    end
    e_level = 4'(q.size());
    e_bclk = ((t/BH) % 2) == 1;
    c = slot % SB;
    e_lrck = started && slot >= SB;
    e_dat = started && c >= 1 && c <= 24 && cur[24-c];
  end
  task automatic do_reset();
    i_valid = 0; i_clr_flags = 0; rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    nvec++;
    if ({o_bclk, o_lrck, o_dacdat, o_frame, o_level, o_overflow, o_underrun} !== 10'd0) begin
      nerr++;
      $display("FAIL reset outputs got %b required 0", {o_bclk, o_lrck, o_dacdat, o_frame, o_level, o_overflow, o_underrun});
    end
    rst = 0;
  endtask
  task automatic test_timing();
    do_reset();
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      nvec++;
      if ({o_bclk, o_frame, o_lrck} !== {e_bclk, e_frame, e_lrck}) begin
        nerr++;
        $display("FAIL timing t=%0d bclk/frame/lrck got %b required %b", t, {o_bclk, o_frame, o_lrck}, {e_bclk, e_frame, e_lrck});
      end
    end
  endtask
  task automatic test_single();
    do_reset();
    i_valid = 1; i_sample = 24'h800001;
    @(negedge clk);
    i_valid = 0;
    for (int i = 0; i < 540; i++) begin
      @(negedge clk);
      nvec++;
      if ({o_dacdat, o_lrck, o_level} !== {e_dat, e_lrck, e_level}) begin
        nerr++;
        $display("FAIL single t=%0d dat/lrck/level got %b required %b", t, {o_dacdat, o_lrck, o_level}, {e_dat, e_lrck, e_level});
      end
    end
  endtask
  task automatic test_back_to_back();
    do_reset();
    i_valid = 1; i_sample = 24'h7FFFFF;
    @(negedge clk);
    i_sample = 24'h123456;
    @(negedge clk);
    i_sample = 24'($urandom);
    @(negedge clk);
    i_valid = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      nvec++;
      if ({o_dacdat, o_lrck, o_frame, o_level} !== {e_dat, e_lrck, e_frame, e_level}) begin
        nerr++;
        $display("FAIL b2b t=%0d dat/lrck/frame/level got %b required %b", t, {o_dacdat, o_lrck, o_frame, o_level}, {e_dat, e_lrck, e_frame, e_level});
      end
    end
  endtask
  task automatic test_underrun();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      nvec++;
      if ({o_dacdat, o_underrun} !== {e_dat, e_unr}) begin
        nerr++;
        $display("FAIL underrun t=%0d dat/unr got %b required %b", t, {o_dacdat, o_underrun}, {e_dat, e_unr});
      end
      if (i == 100) begin
        nvec++;
        if (o_underrun !== 1'b1) begin nerr++; $display("FAIL underrun_set got %b required 1", o_underrun); end
      end
      if (i == 110) begin
        nvec++;
        if (o_underrun !== 1'b0) begin nerr++; $display("FAIL underrun_clr got %b required 0", o_underrun); end
      end
      i_clr_flags = (i == 105) || (i == 258);
    end
  endtask
  task automatic test_overflow();
    do_reset();
    repeat (10) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      i_valid = 1; i_sample = 24'($urandom);
      @(negedge clk);
    end
    i_valid = 0;
    nvec++;
    if ({o_level, o_overflow} !== {4'd8, 1'b1}) begin
      nerr++;
      $display("FAIL overflow_full level/ovf got %b required %b", {o_level, o_overflow}, {4'd8, 1'b1});
    end
    for (int i = 0; i < 256*9 + 40; i++) begin
      @(negedge clk);
      nvec++;
      if ({o_dacdat, o_level, o_overflow, o_underrun} !== {e_dat, e_level, e_ovf, e_unr}) begin
        nerr++;
        $display("FAIL overflow t=%0d dat/level/ovf/unr got %b required %b", t, {o_dacdat, o_level, o_overflow, o_underrun}, {e_dat, e_level, e_ovf, e_unr});
      end
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      nvec++;
      if ({o_bclk, o_lrck, o_dacdat, o_frame, o_level, o_overflow, o_underrun} !==
          {e_bclk, e_lrck, e_dat, e_frame, e_level, e_ovf, e_unr}) begin
        nerr++;
        $display("FAIL random t=%0d outputs got %b required %b", t,
          {o_bclk, o_lrck, o_dacdat, o_frame, o_level, o_overflow, o_underrun},
          {e_bclk, e_lrck, e_dat, e_frame, e_level, e_ovf, e_unr});
      end
      i_valid = $urandom_range(0, 149) == 0 || (t % 256 == 3 && q.size() == DEPTH);
      i_sample = 24'($urandom);
      i_clr_flags = $urandom_range(0, 299) == 0;
    end
    i_valid = 0; i_clr_flags = 0;
  endtask
  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      i_valid = 1; i_sample = 24'($urandom);
      @(negedge clk);
    end
    i_valid = 0;
    for (int i = 0; i < 400 && !(t == 165); i++) @(negedge clk);
    nvec++;
    if (t != 165) begin nerr++; $display("FAIL reset_mid_reach t=%0d required 165", t); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    nvec++;
    if ({o_bclk, o_lrck, o_dacdat, o_frame, o_level, o_overflow, o_underrun} !== 10'd0) begin
      nerr++;
      $display("FAIL reset_mid outputs got %b required 0", {o_bclk, o_lrck, o_dacdat, o_frame, o_level, o_overflow, o_underrun});
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      nvec++;
      if ({o_bclk, o_lrck, o_dacdat, o_frame, o_level, o_underrun} !== {e_bclk, e_lrck, e_dat, e_frame, e_level, e_unr}) begin
        nerr++;
        $display("FAIL reset_mid_after t=%0d got %b required %b", t,
          {o_bclk, o_lrck, o_dacdat, o_frame, o_level, o_underrun}, {e_bclk, e_lrck, e_dat, e_frame, e_level, e_unr});
      end
    end
  endtask
  initial begin
    test_reset();
    test_timing();
    test_single();
    test_back_to_back();
    test_underrun();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
